// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline. It resolves data-memory
// freeze, branch redirects, load-use and imem waits, and keeps per-cause counters.
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        Rs1D,
  input  logic [4:0]        Rs2D,
  input  logic [4:0]        RdE,
  input  logic              LoadE,
  input  logic              PCSrcE,
  input  logic              IMemReady,
  input  logic              DMemReqM,
  input  logic              DMemReadyM,
  input  logic [1:0]        PerfSel,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic              BusErr,
  output logic              ErrSticky,
  output logic [PERF_W-1:0] PerfData
);
  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0]     wait_cnt;
  logic [PERF_W-1:0] perf_cnt [4];
  logic              dwait, timeout, freeze, lwstall;
  logic              win_freeze, win_redir, win_lw, win_iwait;

  function automatic logic load_use(input logic ld, input logic [4:0] rd,
                                    input logic [4:0] rs1, input logic [4:0] rs2);
    return ld & (rd != 5'd0) & ((rd == rs1) | (rd == rs2));
  endfunction

  always_comb begin
    dwait   = DMemReqM & ~DMemReadyM;
    timeout = dwait & (wait_cnt == CW'(TIMEOUT - 1));
    freeze  = dwait & ~timeout;
    lwstall = load_use(LoadE, RdE, Rs1D, Rs2D);
  end

  // Exactly one cause wins per cycle; a held pipe keeps lower causes pending.
  always_comb begin
    win_freeze = ~reset & freeze;
    win_redir  = ~reset & ~freeze & PCSrcE;
    win_lw     = ~reset & ~freeze & ~PCSrcE & lwstall;
    win_iwait  = ~reset & ~freeze & ~PCSrcE & ~lwstall & ~IMemReady;
  end

  always_comb begin
    StallF   = win_freeze | win_lw | win_iwait;
    StallD   = win_freeze | win_lw;
    StallE   = win_freeze;
    StallM   = win_freeze;
    FlushD   = win_redir | win_iwait;
    FlushE   = win_redir | win_lw;
    FlushW   = win_freeze;
    BusErr   = ~reset & timeout;
    PerfData = perf_cnt[PerfSel];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt  <= '0;
      ErrSticky <= 1'b0;
      for (int i = 0; i < 4; i++) perf_cnt[i] <= '0;
    end else begin
      // The timeout cycle clears the window so a still-pending request starts fresh.
      wait_cnt <= freeze ? wait_cnt + CW'(1) : '0;
      if (BusErr)     ErrSticky   <= 1'b1;
      if (win_lw)     perf_cnt[0] <= perf_cnt[0] + PERF_W'(1);
      if (win_iwait)  perf_cnt[1] <= perf_cnt[1] + PERF_W'(1);
      if (win_freeze) perf_cnt[2] <= perf_cnt[2] + PERF_W'(1);
      if (win_redir)  perf_cnt[3] <= perf_cnt[3] + PERF_W'(1);
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random cycles, checked
// against a cycle-level reference model kept in the bench.
module tb_pipeline_hazard_ctrl;
  localparam int TO = 16;

  logic       clk, reset;
  logic [4:0] Rs1D, Rs2D, RdE;
  logic       LoadE, PCSrcE, IMemReady, DMemReqM, DMemReadyM;
  logic [1:0] PerfSel;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, BusErr, ErrSticky;
  logic [31:0] PerfData;
  logic       wStallF, wStallD, wStallE, wStallM, wFlushD, wFlushE, wFlushW, wBusErr, wErrSticky;
  logic [3:0] wPerfData;

  pipeline_hazard_ctrl #(.TIMEOUT(TO), .PERF_W(32)) u_dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE), .LoadE(LoadE),
    .PCSrcE(PCSrcE), .IMemReady(IMemReady), .DMemReqM(DMemReqM), .DMemReadyM(DMemReadyM),
    .PerfSel(PerfSel), .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .BusErr(BusErr),
    .ErrSticky(ErrSticky), .PerfData(PerfData));

  pipeline_hazard_ctrl #(.TIMEOUT(TO), .PERF_W(4)) u_w (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE), .LoadE(LoadE),
    .PCSrcE(PCSrcE), .IMemReady(IMemReady), .DMemReqM(DMemReqM), .DMemReadyM(DMemReadyM),
    .PerfSel(PerfSel), .StallF(wStallF), .StallD(wStallD), .StallE(wStallE), .StallM(wStallM),
    .FlushD(wFlushD), .FlushE(wFlushE), .FlushW(wFlushW), .BusErr(wBusErr),
    .ErrSticky(wErrSticky), .PerfData(wPerfData));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: length of the current freeze run, sticky flag, per-cause counts.
  int          m_run;
  logic        m_sticky;
  int unsigned mc [4];
  int          m_cause;
  logic        m_freeze, m_buserr;

  // Output vector order: StallF StallD StallE StallM FlushD FlushE FlushW BusErr
  localparam logic [7:0] O_FREEZE = 8'b1111_0010;
  localparam logic [7:0] O_REDIR  = 8'b0000_1100;
  localparam logic [7:0] O_LW     = 8'b1100_0100;
  localparam logic [7:0] O_IWAIT  = 8'b1000_1000;
  localparam logic [7:0] O_TOUT   = 8'b0000_0001;

  function automatic logic [7:0] outv();
    return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, BusErr};
  endfunction

  function automatic logic [7:0] outw();
    return {wStallF, wStallD, wStallE, wStallM, wFlushD, wFlushE, wFlushW, wBusErr};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Settle combinational outputs and compare everything against the model.
  task automatic settle_check();
    logic       dw, to, fr, lw;
    logic [7:0] e;
    #1;
    dw = DMemReqM && !DMemReadyM;
    to = dw && (m_run == TO - 1);
    fr = dw && !to;
    lw = LoadE && (RdE != 5'd0) && (RdE == Rs1D || RdE == Rs2D);
    e = 8'h00;
    m_cause = -1;
    if (reset)           e = 8'h00;
    else if (fr)         begin e = O_FREEZE; m_cause = 2; end
    else if (PCSrcE)     begin e = O_REDIR;  m_cause = 3; end
    else if (lw)         begin e = O_LW;     m_cause = 0; end
    else if (!IMemReady) begin e = O_IWAIT;  m_cause = 1; end
    m_buserr = !reset && to;
    if (m_buserr) e = e | O_TOUT;
    m_freeze = fr;
    chk("outs", {24'd0, outv()}, {24'd0, e});
    chk("outs_w", {24'd0, outw()}, {24'd0, e});
    chk("perf", PerfData, mc[PerfSel]);
    chk("perf_w4", {28'd0, wPerfData}, mc[PerfSel] & 32'hF);
    chk("sticky", {31'd0, ErrSticky}, {31'd0, m_sticky});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) begin
      m_run = 0;
      m_sticky = 1'b0;
      for (int i = 0; i < 4; i++) mc[i] = 0;
    end else begin
      m_run = m_freeze ? m_run + 1 : 0;
      if (m_buserr) m_sticky = 1'b1;
      if (m_cause >= 0) mc[m_cause] = mc[m_cause] + 1;
    end
  endtask

  task automatic cyc();
    settle_check();
    tick();
  endtask

  task automatic idle();
    reset = 0; Rs1D = 0; Rs2D = 0; RdE = 0; LoadE = 0; PCSrcE = 0;
    IMemReady = 1; DMemReqM = 0; DMemReadyM = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    cyc();
    cyc();
    reset = 0;
  endtask

  initial begin
    m_run = 0; m_sticky = 1'b0; m_cause = -1; m_freeze = 0; m_buserr = 0;
    for (int i = 0; i < 4; i++) mc[i] = 0;
    PerfSel = 0;
    idle();
    @(posedge clk);
    #1;
    do_reset();

    // Reset state: all counters read zero, sticky clear.
    for (int s = 0; s < 4; s++) begin
      PerfSel = 2'(s);
      #1;
      chk("reset_perf", PerfData, 32'd0);
    end
    chk("reset_sticky", {31'd0, ErrSticky}, 32'd0);

    // Load-use hazard, then the same pattern with r0 which must not stall.
    PerfSel = 0;
    LoadE = 1; RdE = 5; Rs1D = 5;
    settle_check();
    chk("lw_stall", {24'd0, outv()}, {24'd0, O_LW});
    tick();
    RdE = 0; Rs1D = 0;
    settle_check();
    chk("lw_r0", {24'd0, outv()}, 32'd0);
    tick();
    idle();
    settle_check();
    chk("lw_count", PerfData, 32'd1);
    tick();

    // Branch redirect during an imem wait, then the plain imem wait.
    do_reset();
    IMemReady = 0; PCSrcE = 1;
    settle_check();
    chk("br_iwait", {24'd0, outv()}, {24'd0, O_REDIR});
    tick();
    PCSrcE = 0;
    settle_check();
    chk("iwait", {24'd0, outv()}, {24'd0, O_IWAIT});
    tick();
    idle();
    PerfSel = 3; #1; chk("redir_count", PerfData, 32'd1);
    PerfSel = 1; #1; chk("iwait_count", PerfData, 32'd1);

    // Three dmem wait cycles hold a pending redirect; it fires on the ready cycle.
    do_reset();
    PCSrcE = 1; DMemReqM = 1; DMemReadyM = 0;
    for (int i = 0; i < 3; i++) begin
      settle_check();
      chk("dwait_freeze", {24'd0, outv()}, {24'd0, O_FREEZE});
      tick();
    end
    DMemReadyM = 1;
    settle_check();
    chk("dwait_ready", {24'd0, outv()}, {24'd0, O_REDIR});
    tick();
    idle();
    PerfSel = 2; #1; chk("dwait_count", PerfData, 32'd3);

    // Timeout: 20 consecutive wait cycles, abort at cycle 15, fresh window after.
    do_reset();
    PerfSel = 2;
    DMemReqM = 1; DMemReadyM = 0;
    for (int i = 0; i < 20; i++) begin
      settle_check();
      if (i == 15) chk("tout_pulse", {24'd0, outv()}, {24'd0, O_TOUT});
      else         chk("tout_freeze", {24'd0, outv()}, {24'd0, O_FREEZE});
      if (i >= 16) chk("tout_sticky", {31'd0, ErrSticky}, 32'd1);
      tick();
    end
    chk("tout_count", PerfData, 32'd19);

    // Reset in the middle of a wait: no error, fresh window, counters restart.
    idle();
    settle_check();
    tick();
    DMemReqM = 1; DMemReadyM = 0;
    for (int i = 0; i < 5; i++) cyc();
    reset = 1;
    settle_check();
    chk("midrst_outs", {24'd0, outv()}, 32'd0);
    tick();
    reset = 0;
    for (int j = 0; j < 16; j++) begin
      settle_check();
      chk("midrst_sticky", {31'd0, ErrSticky}, 32'd0);
      chk("midrst_count", PerfData, 32'(j));
      if (j == 15) chk("midrst_tout", {24'd0, outv()}, {24'd0, O_TOUT});
      tick();
    end

    // Counter wrap on the 4-bit instance: 17 load-use cycles read back as 1.
    do_reset();
    PerfSel = 0;
    LoadE = 1; RdE = 7; Rs2D = 7;
    for (int i = 0; i < 17; i++) cyc();
    idle();
    #1;
    chk("wrap4", {28'd0, wPerfData}, 32'd1);
    chk("wrap32", PerfData, 32'd17);

    // Random traffic, with slow-memory phases to provoke timeouts.
    for (int i = 0; i < 1500; i++) begin
      logic slow;
      slow       = ((i / 100) % 2) == 1;
      reset      = ($urandom_range(0, 79) == 0);
      Rs1D       = 5'($urandom_range(0, 3));
      Rs2D       = 5'($urandom_range(0, 3));
      RdE        = 5'($urandom_range(0, 3));
      LoadE      = 1'($urandom_range(0, 1));
      PCSrcE     = ($urandom_range(0, 5) == 0);
      IMemReady  = ($urandom_range(0, 3) != 0);
      DMemReqM   = slow ? ($urandom_range(0, 15) != 0) : 1'($urandom_range(0, 1));
      DMemReadyM = slow ? ($urandom_range(0, 24) == 0) : 1'($urandom_range(0, 1));
      PerfSel    = 2'($urandom_range(0, 3));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Drives the enable (via Stall*) and clear (via Flush*) inputs of the F/D, D/E, E/M and M/W pipeline registers.
- Resolves load-use hazards, taken-branch redirects, instruction-memory wait states and data-memory wait states, with a data-memory timeout watchdog.
- Keeps per-cause performance counters that software and the testbench can read.

Parameters:
- TIMEOUT, 16: consecutive data-memory wait cycles before the access is aborted. Must be ≥ 2.
- PERF_W, 32: width of each performance counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Rs1D  in  5  source register 1 of the instruction in Decode.
- Rs2D  in  5  source register 2 of the instruction in Decode.
- RdE  in  5  destination register of the instruction in Execute.
- LoadE  in  1  instruction in Execute is a load.
- PCSrcE  in  1  taken branch/jump resolved in Execute.
- IMemReady  in  1  instruction memory returns valid InstrF this cycle.
- DMemReqM  in  1  instruction in Memory accesses data memory.
- DMemReadyM  in  1  data memory completes the access this cycle.
- PerfSel  in  2  counter select: 0 load-use, 1 imem wait, 2 dmem wait, 3 redirect flushes.
- StallF  out  1  hold the PC register.
- StallD  out  1  hold the F/D register.
- StallE  out  1  hold the D/E register.
- StallM  out  1  hold the E/M register.
- FlushD  out  1  clear the F/D register (bubble).
- FlushE  out  1  clear the D/E register.
- FlushW  out  1  clear the M/W register.
- BusErr  out  1  one-cycle pulse on data-memory timeout.
- ErrSticky  out  1  latched BusErr; cleared only by reset.
- PerfData  out  PERF_W  selected counter value.

Behaviour:
- Reset is synchronous and active-high.
  - On a reset cycle, the next state is: wait_cnt=0, ErrSticky=0, all four counters=0.
  - While reset=1, every Stall*/Flush* output and BusErr is forced to 0.
  - Reset mid-wait abandons the wait with no BusErr.
- dwait = DMemReqM & ~DMemReadyM.
- wait_cnt (width clog2(TIMEOUT)):
  - Increments on cycles where dwait=1 and timeout=0.
  - Clears to 0 otherwise.
- timeout = dwait & (wait_cnt == TIMEOUT-1).
- freeze = dwait & ~timeout.
- lwstall = LoadE & (RdE != 0) & ((RdE == Rs1D) | (RdE == Rs2D)).
- Outputs are combinational. The first matching priority applies; any output not named is 0:
  1. freeze: StallF=StallD=StallE=StallM=1, FlushW=1. PCSrcE and lwstall are ignored and stay pending, because the pipe is held.
  2. PCSrcE: FlushD=1, FlushE=1, StallF=0 so the PC loads the target even during an imem wait.
  3. lwstall: StallF=1, StallD=1, FlushE=1.
  4. ~IMemReady: StallF=1, FlushD=1.
  5. none of the above: all outputs 0.
- Data-memory timeout:
  - On the timeout cycle the freeze releases and the M instruction retires as-is (load data undefined).
  - BusErr=1 for exactly that cycle; ErrSticky is set on the next edge.
  - If DMemReqM is still 1 on the following cycle (new M instruction), a fresh TIMEOUT window starts from 0.
- DMemReadyM=1 in the same cycle as DMemReqM gives no stall and no count.
- Performance counters:
  - Each counter increments by 1 on a cycle where its cause is the *winning* priority: freeze→cnt2, PCSrcE→cnt3, lwstall→cnt0, ~IMemReady→cnt1.
  - Counters wrap modulo 2^PERF_W and do not count while reset=1.
  - PerfData = counter[PerfSel], combinational.

Test Plan:
- Load-use: LoadE=1, RdE=5, Rs1D=5, IMemReady=1 for one cycle → StallF=StallD=FlushE=1 that cycle only; with RdE=0, no stall. PerfSel=0 reads 1.
- Branch during imem wait: IMemReady=0, PCSrcE=1 → StallF=0, FlushD=FlushE=1. Next cycle with PCSrcE=0 → StallF=1, FlushD=1. PerfSel=3 reads 1, PerfSel=1 reads 1.
- Dmem wait of 3 cycles: DMemReqM=1, DMemReadyM=0 for 3 cycles, then 1, with PCSrcE=1 throughout → Stall F/D/E/M=1, FlushW=1, FlushD/FlushE=0 for those 3 cycles. In the ready cycle FlushD=FlushE=1. PerfSel=2 reads 3.
- Timeout with TIMEOUT=16: DMemReqM=1, DMemReadyM=0 held 20 cycles.
  - Cycles 0-14 freeze.
  - Cycle 15: all Stall*=0 and BusErr=1.
  - Cycles 16-19 freeze again.
  - ErrSticky=1 from cycle 16.
  - PerfSel=2 reads 19.
- Reset mid-wait: reset=1 at wait cycle 5 → outputs 0 that cycle. After release, with dwait still 1, timeout occurs 15 cycles later. ErrSticky=0, counters restart from 0.
- Counter wrap with PERF_W=4: 17 load-use cycles → PerfSel=0 reads 1.
